alu_address: RTL and testbench

LC-3 datapath address adder. Forms the effective address for PC-relative, base+offset, branch, JSR and load/store operations as ADDR1 + ADDR2, where ADDR1 is PC or SR1 and ADDR2 is zero or a sign-extended IR offset field. It sits between the IR/PC/register file and the MARMUX/PCMUX.
- The selected offset is also exported on its own for debug and datapath use.
- An optional registered output stage supports pipelined timing closure.

---
 rtl/alu_address.sv | 63 ++++++
 tb/tb_alu_address.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_address.sv
// LC-3 address adder: ADDR1 (PC or SR1) plus ADDR2 (zero or a sign-extended IR offset).
// Define ALU_ADDR_REG_OUT_EN to drive ALU_ADDR_output from a strobe-loaded register.
module alu_address (
  input  logic        Clk,
  input  logic        reset,
  input  logic        load,
  input  logic        LD_BEN,
  input  logic        ADDR1MUX,
  input  logic [1:0]  ADDR2MUX,
  input  logic [15:0] IR_output,
  input  logic [15:0] PC_reg_output,
  input  logic [15:0] SR1_output,
  output logic [15:0] ALU_ADDR_output,
  output logic [15:0] SEXT_output
);

  logic [15:0] addr1;
  logic [15:0] addr2;
  logic [15:0] sum;

  // Explicit case arms keep an unknown on an unselected operand from leaking through
  always_comb begin
    addr1 = PC_reg_output;
    if (ADDR1MUX)
      addr1 = SR1_output;
  end

  always_comb begin
    addr2 = 16'h0000;
    case (ADDR2MUX)
      2'b00:   addr2 = 16'h0000;
      2'b01:   addr2 = {{10{IR_output[5]}}, IR_output[5:0]};
      2'b10:   addr2 = {{7{IR_output[8]}},  IR_output[8:0]};
      2'b11:   addr2 = {{5{IR_output[10]}}, IR_output[10:0]};
      default: addr2 = 16'h0000;
    endcase
  end

  assign sum         = addr1 + addr2;
  assign SEXT_output = addr2;

`ifdef ALU_ADDR_REG_OUT_EN
  logic [15:0] addr_reg;
  logic        unused_ir_bits;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)
      addr_reg <= 16'h0000;
    else if (load | LD_BEN)
      addr_reg <= sum;
  end

  assign ALU_ADDR_output = addr_reg;
  assign unused_ir_bits  = ^IR_output[15:11];
`else
  logic unused_inputs;

  assign ALU_ADDR_output = sum;
  // Clock, reset and strobes only matter for the registered build
  assign unused_inputs   = ^{Clk, reset, load, LD_BEN, IR_output[15:11]};
`endif

endmodule

// File: tb/tb_alu_address.sv
// Directed self-checking bench for alu_address; define ALU_ADDR_REG_OUT_EN to exercise the registered build.
module tb_alu_address;

  logic        Clk = 1'b0;
  logic        reset;
  logic        load;
  logic        LD_BEN;
  logic        ADDR1MUX;
  logic [1:0]  ADDR2MUX;
  logic [15:0] IR_output;
  logic [15:0] PC_reg_output;
  logic [15:0] SR1_output;
  logic [15:0] ALU_ADDR_output;
  logic [15:0] SEXT_output;

  int errors = 0;
  int checks = 0;

  alu_address dut (
    .Clk(Clk),
    .reset(reset),
    .load(load),
    .LD_BEN(LD_BEN),
    .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX),
    .IR_output(IR_output),
    .PC_reg_output(PC_reg_output),
    .SR1_output(SR1_output),
    .ALU_ADDR_output(ALU_ADDR_output),
    .SEXT_output(SEXT_output)
  );

  always #5 Clk = ~Clk;

  task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] pc,
                               input logic [15:0] sr1, input logic a1, input logic [1:0] a2);
    IR_output     = ir;
    PC_reg_output = pc;
    SR1_output    = sr1;
    ADDR1MUX      = a1;
    ADDR2MUX      = a2;
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // In the registered build the sum only reaches the output after a load strobe
  task automatic checkOutput(input string tag, input logic [15:0] exp_sext, input logic [15:0] exp_addr);
`ifdef ALU_ADDR_REG_OUT_EN
    @(negedge Clk);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
`else
    #1;
`endif
    checkValue({tag, "_sext"}, SEXT_output, exp_sext);
    checkValue({tag, "_addr"}, ALU_ADDR_output, exp_addr);
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    LD_BEN = 1'b0;
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 1'b0, 2'b00);
    #2;
    checkValue("reset_addr", ALU_ADDR_output, 16'h0000);
    @(negedge Clk);
    reset = 1'b0;

    applyStimulus(16'h0001, 16'h0000, 16'h0000, 1'b0, 2'b01);
    checkOutput("ir0001_a2_01", 16'h0001, 16'h0001);
    applyStimulus(16'h0001, 16'h0000, 16'h0000, 1'b0, 2'b00);
    checkOutput("ir0001_a2_00", 16'h0000, 16'h0000);

    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2'b00);
    checkOutput("irFFFF_a2_00", 16'h0000, 16'h0000);
    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2'b01);
    checkOutput("irFFFF_a2_01", 16'hFFFF, 16'hFFFF);
    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2'b10);
    checkOutput("irFFFF_a2_10", 16'hFFFF, 16'hFFFF);
    applyStimulus(16'hFFFF, 16'h0000, 16'h0000, 1'b0, 2'b11);
    checkOutput("irFFFF_a2_11", 16'hFFFF, 16'hFFFF);

    // 0x0520 has bits 5, 8 and 10 set, so every field is negative
    applyStimulus(16'h0520, 16'h0000, 16'h0000, 1'b0, 2'b00);
    checkOutput("ir0520_a2_00", 16'h0000, 16'h0000);
    applyStimulus(16'h0520, 16'h0000, 16'h0000, 1'b0, 2'b01);
    checkOutput("ir0520_a2_01", 16'hFFE0, 16'hFFE0);
    applyStimulus(16'h0520, 16'h0000, 16'h0000, 1'b0, 2'b10);
    checkOutput("ir0520_a2_10", 16'hFF20, 16'hFF20);
    applyStimulus(16'h0520, 16'h0000, 16'h0000, 1'b0, 2'b11);
    checkOutput("ir0520_a2_11", 16'hFD20, 16'hFD20);

    applyStimulus(16'h0001, 16'h0001, 16'h0010, 1'b1, 2'b01);
    checkOutput("sr1_base", 16'h0001, 16'h0011);
    applyStimulus(16'h0001, 16'h0001, 16'h0010, 1'b0, 2'b01);
    checkOutput("pc_base", 16'h0001, 16'h0002);

    applyStimulus(16'h0001, 16'hFFFF, 16'h0000, 1'b0, 2'b01);
    checkOutput("wrap_ffff_plus_1", 16'h0001, 16'h0000);
    applyStimulus(16'h003F, 16'h0000, 16'h0000, 1'b0, 2'b01);
    checkOutput("zero_plus_ffff", 16'hFFFF, 16'hFFFF);
    applyStimulus(16'h07FF, 16'h8000, 16'h0000, 1'b0, 2'b11);
    checkOutput("wrap_8000_minus_1", 16'hFFFF, 16'h7FFF);
    applyStimulus(16'h0042, 16'h1000, 16'h2000, 1'b1, 2'b10);
    checkOutput("sr1_off9_pos", 16'h0042, 16'h2042);

    // Bits above the selected field must be ignored
    applyStimulus(16'hF805, 16'h0000, 16'h0000, 1'b0, 2'b11);
    checkOutput("ir_high_bits", 16'h0005, 16'h0005);
    applyStimulus(16'hFFC3, 16'h0100, 16'h0000, 1'b0, 2'b01);
    checkOutput("ir_off6_high", 16'h0003, 16'h0103);

    applyStimulus('x, 16'h0100, 'x, 1'b0, 2'b00);
    checkOutput("x_unselected", 16'h0000, 16'h0100);

`ifdef ALU_ADDR_REG_OUT_EN
    applyStimulus(16'h0000, 16'h5555, 16'h0000, 1'b0, 2'b00);
    checkOutput("preload_5555", 16'h0000, 16'h5555);
    @(posedge Clk);
    #2;
    reset = 1'b1;
    #1;
    checkValue("async_reset", ALU_ADDR_output, 16'h0000);
    load = 1'b1;
    @(negedge Clk);
    checkValue("reset_blocks_load", ALU_ADDR_output, 16'h0000);
    load  = 1'b0;
    reset = 1'b0;
    @(negedge Clk);
    checkValue("no_capture_after_reset", ALU_ADDR_output, 16'h0000);

    applyStimulus(16'h0000, 16'h1234, 16'h0000, 1'b0, 2'b00);
    @(negedge Clk);
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    checkValue("load_1234", ALU_ADDR_output, 16'h1234);

    applyStimulus(16'h0000, 16'h9999, 16'h0000, 1'b0, 2'b00);
    @(negedge Clk);
    @(negedge Clk);
    checkValue("hold_1234", ALU_ADDR_output, 16'h1234);

    applyStimulus(16'h0002, 16'h0040, 16'h0000, 1'b0, 2'b01);
    @(negedge Clk);
    LD_BEN = 1'b1;
    @(negedge Clk);
    LD_BEN = 1'b0;
    checkValue("ld_ben_0042", ALU_ADDR_output, 16'h0042);

    applyStimulus(16'h0000, 16'h0777, 16'h0000, 1'b0, 2'b00);
    @(negedge Clk);
    load   = 1'b1;
    LD_BEN = 1'b1;
    @(negedge Clk);
    load   = 1'b0;
    LD_BEN = 1'b0;
    checkValue("both_strobes", ALU_ADDR_output, 16'h0777);
`else
    // Strobes and reset are inert in the combinational build
    reset  = 1'b1;
    load   = 1'b1;
    LD_BEN = 1'b1;
    applyStimulus(16'h0000, 16'h0ABC, 16'h0000, 1'b0, 2'b00);
    @(negedge Clk);
    @(negedge Clk);
    checkValue("comb_ignores_reset", ALU_ADDR_output, 16'h0ABC);
    reset  = 1'b0;
    load   = 1'b0;
    LD_BEN = 1'b0;
    applyStimulus(16'h0000, 16'h0ABD, 16'h0000, 1'b0, 2'b00);
    checkValue("comb_no_strobe", ALU_ADDR_output, 16'h0ABD);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
